plot_scheduler: RTL and testbench

- Shares the single VGA pixel-write port between the game objects (ball, paddle, block field), which each raise a one-cycle plot request carrying old and new rectangles.
- Per granted request, erases the old rectangle with the background colour, then draws the new rectangle in the object colour, one pixel per clock.
- Sits between the game-logic modules and the vga_adapter, replacing their direct plot wiring.

---
 rtl/plot_scheduler_pkg.sv | 10 +
 rtl/plot_scheduler_rect_scanner.sv | 55 +++++
 rtl/plot_scheduler.sv | 160 ++++++++++++++++
 tb/tb_plot_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/plot_scheduler_pkg.sv
// plot_pkg: shared state encoding, requester indices and coordinate widths
package plot_pkg;
    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int C_W    = 3;
    localparam int BALL   = 0;
    localparam int PADDLE = 1;
    localparam int BLOCK  = 2;
    typedef enum logic [2:0] {S_IDLE, S_ARB, S_ERASE, S_DRAW, S_FIN} state_t;
endpackage

// File: rtl/plot_scheduler_rect_scanner.sv
// rect_scanner: walks a rectangle x-fastest, one registered pixel per clock, clipping off-screen pixels
module rect_scanner
    import plot_pkg::*;
#(
    parameter int MAX_X = 159,
    parameter int MAX_Y = 119
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           i_run,
    input  logic [X_W-1:0] i_base_x,
    input  logic [Y_W-1:0] i_base_y,
    input  logic [X_W-1:0] i_size_x,
    input  logic [Y_W-1:0] i_size_y,
    input  logic [C_W-1:0] i_colour,
    output logic           o_last,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic [C_W-1:0] o_colour,
    output logic           o_plot
);
    logic [X_W-1:0] r_cx, r_x;
    logic [Y_W-1:0] r_cy, r_y;
    logic [C_W-1:0] r_col;
    logic           r_plot;
    logic           w_end_x, w_end_y;
    logic [X_W:0]   w_px;
    logic [Y_W:0]   w_py;
    assign w_end_x  = r_cx == i_size_x - X_W'(1);
    assign w_end_y  = r_cy == i_size_y - Y_W'(1);
    assign o_last   = w_end_x && w_end_y;
    assign w_px     = {1'b0, i_base_x} + {1'b0, r_cx};
    assign w_py     = {1'b0, i_base_y} + {1'b0, r_cy};
    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_colour = r_col;
    assign o_plot   = r_plot;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cx   <= '0;
            r_cy   <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_col  <= '0;
            r_plot <= 1'b0;
        end else begin
            r_cx   <= (!i_run || w_end_x) ? '0 : r_cx + X_W'(1);
            r_cy   <= (!i_run || o_last) ? '0 : (w_end_x ? r_cy + Y_W'(1) : r_cy);
            r_x    <= w_px[X_W-1:0];
            r_y    <= w_py[Y_W-1:0];
            r_col  <= i_colour;
            r_plot <= i_run && (w_px <= (X_W+1)'(MAX_X)) && (w_py <= (Y_W+1)'(MAX_Y));
        end
    end
endmodule

// File: rtl/plot_scheduler.sv
// plot_scheduler: round-robin sharing of one VGA pixel port; erases old then draws new rectangle per request
module plot_scheduler
    import plot_pkg::*;
#(
    parameter int             N_REQ     = 3,
    parameter int             MAX_X     = 159,
    parameter int             MAX_Y     = 119,
    parameter logic [C_W-1:0] BG_COLOUR = 3'b000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [N_REQ-1:0]     req,
    input  logic [X_W*N_REQ-1:0] req_new_x,
    input  logic [Y_W*N_REQ-1:0] req_new_y,
    input  logic [X_W*N_REQ-1:0] req_old_x,
    input  logic [Y_W*N_REQ-1:0] req_old_y,
    input  logic [X_W*N_REQ-1:0] req_size_x,
    input  logic [Y_W*N_REQ-1:0] req_size_y,
    input  logic [C_W*N_REQ-1:0] req_colour,
    output logic [N_REQ-1:0]     ack,
    output logic                 busy,
    output logic [X_W-1:0]       vga_x,
    output logic [Y_W-1:0]       vga_y,
    output logic [C_W-1:0]       vga_colour,
    output logic                 vga_plot
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    state_t           r_state, w_next;
    logic [N_REQ-1:0] r_pend, w_clr;
    logic [X_W-1:0]   r_nx [N_REQ];
    logic [X_W-1:0]   r_ox [N_REQ];
    logic [X_W-1:0]   r_sx [N_REQ];
    logic [Y_W-1:0]   r_ny [N_REQ];
    logic [Y_W-1:0]   r_oy [N_REQ];
    logic [Y_W-1:0]   r_sy [N_REQ];
    logic [C_W-1:0]   r_col [N_REQ];
    logic [IW-1:0]    r_ptr, r_gnt, w_gnt, w_idx;
    logic [X_W-1:0]   r_wnx, r_wox, r_wsx;
    logic [Y_W-1:0]   r_wny, r_woy, r_wsy;
    logic [C_W-1:0]   r_wcol;
    logic             r_hold, w_run, w_last, w_any, w_zero, w_erase;
    assign w_any   = |(r_pend | req);
    assign w_zero  = (r_wsx == '0) || (r_wsy == '0);
    assign w_erase = r_state == S_ERASE;
    assign busy    = r_state != S_IDLE;
    // later k overwrite earlier ones, so the nearest pending slot after r_ptr wins
    always_comb begin
        w_gnt = r_ptr;
        w_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % N_REQ);
            if (r_pend[w_idx]) w_gnt = w_idx;
        end
    end
    always_comb begin
        w_clr        = '0;
        w_clr[w_gnt] = (r_state == S_ARB) && |r_pend;
    end
    always_comb begin
        ack        = '0;
        ack[r_gnt] = r_state == S_FIN;
    end
    // sizes are shared by both phases, so a zero size skips the whole erase+draw
    always_comb begin
        w_next = r_state;
        w_run  = 1'b0;
        case (r_state)
            S_IDLE:  w_next = w_any ? S_ARB : S_IDLE;
            S_ARB:   w_next = |r_pend ? S_ERASE : S_IDLE;
            S_ERASE: begin
                w_run  = !w_zero;
                w_next = w_zero ? S_FIN : (w_last ? S_DRAW : S_ERASE);
            end
            S_DRAW: begin
                w_run  = !r_hold;
                w_next = r_hold ? S_FIN : S_DRAW;
            end
            S_FIN:   w_next = w_any ? S_ARB : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end
    // a req always wins over the arbiter's clear; old coords are kept while a capture is still waiting
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                r_nx[i]  <= '0;
                r_ox[i]  <= '0;
                r_sx[i]  <= '0;
                r_ny[i]  <= '0;
                r_oy[i]  <= '0;
                r_sy[i]  <= '0;
                r_col[i] <= '0;
            end
        end else begin
            r_pend <= (r_pend & ~w_clr) | req;
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i]) begin
                    r_nx[i]  <= req_new_x[i*X_W +: X_W];
                    r_ny[i]  <= req_new_y[i*Y_W +: Y_W];
                    r_sx[i]  <= req_size_x[i*X_W +: X_W];
                    r_sy[i]  <= req_size_y[i*Y_W +: Y_W];
                    r_col[i] <= req_colour[i*C_W +: C_W];
                    if (!r_pend[i] || w_clr[i]) begin
                        r_ox[i] <= req_old_x[i*X_W +: X_W];
                        r_oy[i] <= req_old_y[i*Y_W +: Y_W];
                    end
                end
            end
        end
    end
    // r_hold keeps DRAW one extra cycle so the registered last pixel leaves the scanner
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_hold  <= 1'b0;
            r_wnx   <= '0;
            r_wox   <= '0;
            r_wsx   <= '0;
            r_wny   <= '0;
            r_woy   <= '0;
            r_wsy   <= '0;
            r_wcol  <= '0;
        end else begin
            r_state <= w_next;
            r_hold  <= (r_state == S_DRAW) && (r_hold || (w_run && w_last));
            if (r_state == S_ARB) begin
                r_gnt  <= w_gnt;
                r_ptr  <= w_gnt;
                r_wnx  <= r_nx[w_gnt];
                r_wox  <= r_ox[w_gnt];
                r_wsx  <= r_sx[w_gnt];
                r_wny  <= r_ny[w_gnt];
                r_woy  <= r_oy[w_gnt];
                r_wsy  <= r_sy[w_gnt];
                r_wcol <= r_col[w_gnt];
            end
        end
    end
    rect_scanner #(
        .MAX_X(MAX_X),
        .MAX_Y(MAX_Y)
    ) u_scan (
        .clk      (clk),
        .resetn   (resetn),
        .i_run    (w_run),
        .i_base_x (w_erase ? r_wox : r_wnx),
        .i_base_y (w_erase ? r_woy : r_wny),
        .i_size_x (r_wsx),
        .i_size_y (r_wsy),
        .i_colour (w_erase ? BG_COLOUR : r_wcol),
        .o_last   (w_last),
        .o_x      (vga_x),
        .o_y      (vga_y),
        .o_colour (vga_colour),
        .o_plot   (vga_plot)
    );
endmodule

// File: tb/tb_plot_scheduler.sv
// tb_plot_scheduler: directed checks of plot order, timing, clipping, re-request and reset for plot_scheduler
module tb_plot_scheduler;
    import plot_pkg::*;
    typedef struct {int c; logic [7:0] x; logic [6:0] y; logic [2:0] col;} pix_t;
    typedef struct {int c; logic [2:0] a;} ack_t;
    logic        clk = 1'b0, resetn = 1'b0;
    logic [2:0]  req = '0;
    logic [23:0] nx = '0, ox = '0, sx = '0;
    logic [20:0] ny = '0, oy = '0, sy = '0;
    logic [8:0]  col = '0;
    logic [2:0]  ack;
    logic        busy, vga_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    int          cyc = 0, arb_cyc = 0, n_chk = 0, n_fail = 0;
    logic        busy_q = 1'b0;
    pix_t        pq[$];
    ack_t        aq[$];
    logic [17:0] eq[$];
    plot_scheduler dut (
        .clk(clk), .resetn(resetn), .req(req),
        .req_new_x(nx), .req_new_y(ny), .req_old_x(ox), .req_old_y(oy),
        .req_size_x(sx), .req_size_y(sy), .req_colour(col),
        .ack(ack), .busy(busy), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (vga_plot) pq.push_back('{cyc, vga_x, vga_y, vga_colour});
        if (ack != 3'b000) aq.push_back('{cyc, ack});
        if (busy && !busy_q) arb_cyc = cyc;
        busy_q = busy;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic clr();
        pq.delete();
        aq.delete();
        eq.delete();
    endtask
    task automatic rst();
        resetn = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        clr();
    endtask
    task automatic load(input int i, input int nxv, nyv, oxv, oyv, sxv, syv, cv);
        nx[i*8 +: 8]  = 8'(nxv);
        ny[i*7 +: 7]  = 7'(nyv);
        ox[i*8 +: 8]  = 8'(oxv);
        oy[i*7 +: 7]  = 7'(oyv);
        sx[i*8 +: 8]  = 8'(sxv);
        sy[i*7 +: 7]  = 7'(syv);
        col[i*3 +: 3] = 3'(cv);
    endtask
    task automatic pulse(input logic [2:0] m);
        @(negedge clk);
        req = m;
        @(negedge clk);
        req = '0;
    endtask
    task automatic add_rect(input int x, y, w, h, c);
        for (int j = 0; j < h; j++)
            for (int i = 0; i < w; i++)
                if (x + i <= 159 && y + j <= 119) eq.push_back({8'(x + i), 7'(y + j), 3'(c)});
    endtask
    task automatic pix_check(input string tag);
        check({tag, "_npix"}, pq.size(), eq.size());
        for (int i = 0; i < pq.size() && i < eq.size(); i++)
            check(tag, {pq[i].x, pq[i].y, pq[i].col}, eq[i]);
    endtask
    task automatic ack_check(input string tag, input int idx, input logic [2:0] exp);
        check(tag, (aq.size() > idx) ? aq[idx].a : 3'b000, exp);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_plot", vga_plot, 0);
        check("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
        check("rst_ack", ack, 0);
        resetn = 1'b1;
        @(negedge clk);
        clr();
        // single ball 4x4
        load(BALL, 50, 4, 49, 3, 4, 4, 7);
        pulse(3'b001);
        repeat (45) @(negedge clk);
        add_rect(49, 3, 4, 4, 0);
        add_rect(50, 4, 4, 4, 7);
        pix_check("t1_pix");
        check("t1_first", (pq.size() > 0 ? pq[0].c : 0) - arb_cyc, 2);
        check("t1_last", (pq.size() == 32 ? pq[31].c : 0) - arb_cyc, 33);
        check("t1_nack", aq.size(), 1);
        ack_check("t1_ack", 0, 3'b001);
        check("t1_cycles", (aq.size() > 0 ? aq[0].c : 0) - arb_cyc + 1, 35);
        check("t1_idle", busy, 0);
        // simultaneous requests after reset
        rst();
        load(BALL, 10, 10, 20, 20, 1, 1, 1);
        load(PADDLE, 30, 30, 40, 40, 1, 1, 2);
        load(BLOCK, 50, 50, 60, 60, 1, 1, 3);
        pulse(3'b111);
        repeat (30) @(negedge clk);
        add_rect(40, 40, 1, 1, 0);
        add_rect(30, 30, 1, 1, 2);
        add_rect(60, 60, 1, 1, 0);
        add_rect(50, 50, 1, 1, 3);
        add_rect(20, 20, 1, 1, 0);
        add_rect(10, 10, 1, 1, 1);
        pix_check("t2_pix");
        check("t2_nack", aq.size(), 3);
        ack_check("t2_ack0", 0, 3'b010);
        ack_check("t2_ack1", 1, 3'b100);
        ack_check("t2_ack2", 2, 3'b001);
        // paddle re-request while pending behind a ball
        rst();
        load(BALL, 11, 10, 10, 10, 2, 2, 1);
        pulse(3'b001);
        load(PADDLE, 99, 50, 100, 50, 1, 1, 2);
        pulse(3'b010);
        load(PADDLE, 98, 51, 99, 50, 1, 1, 3);
        pulse(3'b010);
        repeat (40) @(negedge clk);
        add_rect(10, 10, 2, 2, 0);
        add_rect(11, 10, 2, 2, 1);
        add_rect(100, 50, 1, 1, 0);
        add_rect(98, 51, 1, 1, 3);
        pix_check("t3_pix");
        check("t3_nack", aq.size(), 2);
        ack_check("t3_ack1", 1, 3'b010);
        // clipping at the right edge
        rst();
        load(BALL, 158, 10, 158, 10, 4, 1, 5);
        pulse(3'b001);
        repeat (20) @(negedge clk);
        add_rect(158, 10, 4, 1, 0);
        add_rect(158, 10, 4, 1, 5);
        pix_check("t4_pix");
        check("t4_draw_c", (pq.size() > 2 ? pq[2].c : 0) - arb_cyc, 6);
        check("t4_cycles", (aq.size() > 0 ? aq[0].c : 0) - arb_cyc + 1, 11);
        // zero-size block
        rst();
        load(BLOCK, 5, 5, 5, 5, 0, 0, 4);
        pulse(3'b100);
        repeat (10) @(negedge clk);
        check("t5_npix", pq.size(), 0);
        check("t5_nack", aq.size(), 1);
        ack_check("t5_ack", 0, 3'b100);
        check("t5_lat", (aq.size() > 0 ? aq[0].c : 0) - arb_cyc, 2);
        // reset mid-draw, then a fresh request
        rst();
        load(BALL, 50, 4, 49, 3, 4, 4, 7);
        pulse(3'b001);
        repeat (22) @(negedge clk);
        check("t6_indraw", pq.size() > 16, 1);
        resetn = 1'b0;
        #1;
        check("t6_plot", vga_plot, 0);
        check("t6_busy", busy, 0);
        check("t6_ack", ack, 0);
        check("t6_nack", aq.size(), 0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        clr();
        repeat (5) @(negedge clk);
        check("t6_noack", aq.size(), 0);
        check("t6_idle", busy, 0);
        load(PADDLE, 70, 70, 71, 71, 1, 1, 6);
        pulse(3'b010);
        repeat (10) @(negedge clk);
        add_rect(71, 71, 1, 1, 0);
        add_rect(70, 70, 1, 1, 6);
        pix_check("t6_pix");
        check("t6_nack2", aq.size(), 1);
        ack_check("t6_ack2", 0, 3'b010);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
